// File: rtl/decimal_entry_converter_pkg.sv
// Shared types and constants for the decimal entry converter.
package dec_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int ACC_W = 10;
    localparam logic [ACC_W-1:0] BIN_MAX = 10'd255;
    localparam bcd_digit_t DIGIT_MAX = 4'd9;

endpackage

// File: rtl/decimal_entry_converter_if.sv
// Button/switch inputs and display/result outputs of the decimal entry converter.
interface decimal_entry_converter_if;

    logic [3:0] switches;
    logic       digit_button;
    logic       convert_button;
    logic       clear_button;

    logic [7:0] red_leds;
    logic       overflow_flag;
    logic       invalid_flag;
    logic       busy;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output switches, digit_button, convert_button, clear_button,
        input  red_leds, overflow_flag, invalid_flag, busy,
        input  HEX0, HEX1, HEX2, HEX4, HEX5
    );

    modport slave (
        input  switches, digit_button, convert_button, clear_button,
        output red_leds, overflow_flag, invalid_flag, busy,
        output HEX0, HEX1, HEX2, HEX4, HEX5
    );

endinterface

// File: rtl/decimal_entry_converter_button_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous push-button.
module button_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic pulse_o
);

    logic sync0_q;
    logic sync1_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync0_q <= button_i;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    assign pulse_o = sync1_q & ~prev_q;

endmodule

// File: rtl/seven_segment_display.sv
// Hex nibble to active-low seven-segment pattern (segment order gfedcba).
module seven_segment_display (
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (value_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/decimal_entry_converter.sv
// Decimal digit entry buffer with serial decimal-to-binary conversion.
// Define DEC_ENTRY_SATURATE_EN to saturate red_leds at 8'hFF on overflow instead of wrapping.
module decimal_entry_converter
    import dec_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 3
) (
    input logic                      clk,
    input logic                      reset,
    decimal_entry_converter_if.slave dec_if
);

    localparam logic [ACC_W-1:0] TEN = 10'd10;

    logic digitPulse;
    logic convertPulse;
    logic clearPulse;

    state_t                      state_q,    state_d;
    bcd_digit_t [NUM_DIGITS-1:0] digitBuf_q, digitBuf_d;
    logic [ACC_W-1:0]            acc_q,      acc_d;
    logic [1:0]                  idx_q,      idx_d;
    logic [7:0]                  redLeds_q,  redLeds_d;
    logic                        overflow_q, overflow_d;
    logic                        invalid_q,  invalid_d;

    bcd_digit_t       curDigit;
    bcd_digit_t [2:0] hexDigit;

    button_edge_detect u_digit_edge (
        .clk      (clk),
        .reset    (reset),
        .button_i (dec_if.digit_button),
        .pulse_o  (digitPulse)
    );

    button_edge_detect u_convert_edge (
        .clk      (clk),
        .reset    (reset),
        .button_i (dec_if.convert_button),
        .pulse_o  (convertPulse)
    );

    button_edge_detect u_clear_edge (
        .clk      (clk),
        .reset    (reset),
        .button_i (dec_if.clear_button),
        .pulse_o  (clearPulse)
    );

    // Digit selected by the conversion index, most significant first.
    always_comb begin
        curDigit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 2'(i)) begin
                curDigit = digitBuf_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        digitBuf_d = digitBuf_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        redLeds_d  = redLeds_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;

        case (state_q)
            IDLE: begin
                if (clearPulse) begin
                    digitBuf_d = '0;
                    invalid_d  = 1'b0;
                end else if (convertPulse) begin
                    acc_d   = '0;
                    idx_d   = 2'(NUM_DIGITS - 1);
                    state_d = CONV;
                end else if (digitPulse) begin
                    if (dec_if.switches > DIGIT_MAX) begin
                        invalid_d = 1'b1;
                    end else begin
                        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                            digitBuf_d[i] = digitBuf_q[i-1];
                        end
                        digitBuf_d[0] = dec_if.switches;
                        invalid_d     = 1'b0;
                    end
                end
            end

            CONV: begin
                acc_d = acc_q * TEN + ACC_W'(curDigit);
                if (idx_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end

            DONE: begin
                if (acc_q > BIN_MAX) begin
                    overflow_d = 1'b1;
`ifdef DEC_ENTRY_SATURATE_EN
                    redLeds_d  = 8'hFF;
`else
                    redLeds_d  = acc_q[7:0];
`endif
                end else begin
                    overflow_d = 1'b0;
                    redLeds_d  = acc_q[7:0];
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            digitBuf_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            redLeds_q  <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            digitBuf_q <= digitBuf_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            redLeds_q  <= redLeds_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
        end
    end

    // Display positions beyond the configured digit count show zero.
    always_comb begin
        hexDigit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hexDigit[i] = digitBuf_q[i];
        end
    end

    seven_segment_display u_hex0 (.value_i(hexDigit[0]),     .seg_o(dec_if.HEX0));
    seven_segment_display u_hex1 (.value_i(hexDigit[1]),     .seg_o(dec_if.HEX1));
    seven_segment_display u_hex2 (.value_i(hexDigit[2]),     .seg_o(dec_if.HEX2));
    seven_segment_display u_hex4 (.value_i(redLeds_q[3:0]),  .seg_o(dec_if.HEX4));
    seven_segment_display u_hex5 (.value_i(redLeds_q[7:4]),  .seg_o(dec_if.HEX5));

    assign dec_if.red_leds      = redLeds_q;
    assign dec_if.overflow_flag = overflow_q;
    assign dec_if.invalid_flag  = invalid_q;
    assign dec_if.busy          = (state_q != IDLE);

endmodule
